// File: rtl/saph_raster_pkg.sv
// Shared types for the raster walker: FSM state encoding and coordinate types.
package saph_raster_pkg;

    localparam int unsigned SAPH_XW = 11;
    localparam int unsigned SAPH_YW = 11;

    typedef logic [SAPH_XW-1:0] saph_x_t;
    typedef logic [SAPH_YW-1:0] saph_y_t;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ROW_LOAD = 3'd1,
        ST_ROW_WAIT = 3'd2,
        ST_PIX_LOAD = 3'd3,
        ST_PIX_WAIT = 3'd4,
        ST_EMIT     = 3'd5,
        ST_STEP     = 3'd6
    } saph_raster_state_e;

endpackage

// File: rtl/saph_raster_walker.sv
// Bounding-box raster walker: drives a row and a pixel edge-function
// incrementer, tests coverage per pixel and emits covered fragments in
// raster order. Optional macro SAPH_RASTER_EARLY_EXIT_EN ends a row at the
// first uncovered pixel following a covered one (convex span).
module saph_raster_walker
    import saph_raster_pkg::*;
#(
    parameter int unsigned EDGES = 3,
    parameter int unsigned XW    = SAPH_XW,
    parameter int unsigned YW    = SAPH_YW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [XW-1:0]    bbox_x0,
    input  logic [XW-1:0]    bbox_x1,
    input  logic [YW-1:0]    bbox_y0,
    input  logic [YW-1:0]    bbox_y1,
    output logic             busy,
    output logic             done,
    output logic             row_latch,
    output logic [EDGES-1:0] row_count,
    input  logic             row_ready,
    output logic             pix_latch,
    output logic [EDGES-1:0] pix_count,
    input  logic             pix_ready,
    input  logic [EDGES-1:0] edge_neg,
    output logic             frag_valid,
    input  logic             frag_ready,
    output logic [XW-1:0]    frag_x,
    output logic [YW-1:0]    frag_y
);

    saph_raster_state_e state_q, state_d;
    logic [XW-1:0] x0_q, x0_d, x1_q, x1_d, x_q, x_d;
    logic [YW-1:0] y1_q, y1_d, y_q, y_d;
    logic          busy_q, busy_d, done_q, done_d;
    logic          row_latch_q, row_latch_d, row_count_q, row_count_d;
    logic          pix_latch_q, pix_latch_d, pix_count_q, pix_count_d;
    logic          frag_valid_q, frag_valid_d;
    logic [XW-1:0] frag_x_q, frag_x_d;
    logic [YW-1:0] frag_y_q, frag_y_d;
    logic          do_step;
    logic          end_row;
`ifdef SAPH_RASTER_EARLY_EXIT_EN
    logic          row_hit_q, row_hit_d;
`endif

    // Next-state, counters and registered-output decode.
    always_comb begin
        state_d      = state_q;
        x0_d         = x0_q;
        x1_d         = x1_q;
        y1_d         = y1_q;
        x_d          = x_q;
        y_d          = y_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        row_latch_d  = 1'b0;
        row_count_d  = 1'b0;
        pix_latch_d  = 1'b0;
        pix_count_d  = 1'b0;
        frag_valid_d = frag_valid_q;
        frag_x_d     = frag_x_q;
        frag_y_d     = frag_y_q;
        do_step      = 1'b0;
        end_row      = 1'b0;
`ifdef SAPH_RASTER_EARLY_EXIT_EN
        row_hit_d    = row_hit_q;
`endif

        case (state_q)
            ST_IDLE: begin
                // busy stays high through the done cycle, so start is ignored there
                busy_d = 1'b0;
                if (start && !busy_q) begin
                    x0_d        = bbox_x0;
                    x1_d        = bbox_x1;
                    y1_d        = bbox_y1;
                    x_d         = bbox_x0;
                    y_d         = bbox_y0;
                    busy_d      = 1'b1;
                    row_latch_d = 1'b1;
                    state_d     = ST_ROW_LOAD;
`ifdef SAPH_RASTER_EARLY_EXIT_EN
                    row_hit_d   = 1'b0;
`endif
                end
            end
            ST_ROW_LOAD: begin
                state_d = ST_ROW_WAIT;
            end
            ST_ROW_WAIT: begin
                // ready is stale while a row pulse is still on the wire
                if (!row_latch_q && !row_count_q && row_ready) begin
                    pix_latch_d = 1'b1;
                    x_d         = x0_q;
                    state_d     = ST_PIX_LOAD;
                end
            end
            ST_PIX_LOAD: begin
                state_d = ST_PIX_WAIT;
            end
            ST_PIX_WAIT: begin
                if (!pix_latch_q && !pix_count_q && pix_ready) begin
                    if (edge_neg == '0) begin
                        frag_valid_d = 1'b1;
                        frag_x_d     = x_q;
                        frag_y_d     = y_q;
                        state_d      = ST_EMIT;
`ifdef SAPH_RASTER_EARLY_EXIT_EN
                        row_hit_d    = 1'b1;
`endif
                    end else begin
                        state_d = ST_STEP;
                    end
                end
            end
            ST_EMIT: begin
                // the step is folded into the handshake cycle
                if (frag_ready) begin
                    frag_valid_d = 1'b0;
                    do_step      = 1'b1;
                end
            end
            ST_STEP: begin
                do_step = 1'b1;
`ifdef SAPH_RASTER_EARLY_EXIT_EN
                // only uncovered pixels reach this state
                end_row = row_hit_q;
`endif
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Advance to next pixel, next row, or finish.
        if (do_step) begin
            if (!end_row && (x_q < x1_q)) begin
                x_d         = x_q + XW'(1);
                pix_count_d = 1'b1;
                state_d     = ST_PIX_WAIT;
            end else if (y_q < y1_q) begin
                y_d         = y_q + YW'(1);
                row_count_d = 1'b1;
                state_d     = ST_ROW_WAIT;
`ifdef SAPH_RASTER_EARLY_EXIT_EN
                row_hit_d   = 1'b0;
`endif
            end else begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
        end
    end

    // State, coordinate and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            x0_q         <= '0;
            x1_q         <= '0;
            y1_q         <= '0;
            x_q          <= '0;
            y_q          <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            row_latch_q  <= 1'b0;
            row_count_q  <= 1'b0;
            pix_latch_q  <= 1'b0;
            pix_count_q  <= 1'b0;
            frag_valid_q <= 1'b0;
            frag_x_q     <= '0;
            frag_y_q     <= '0;
`ifdef SAPH_RASTER_EARLY_EXIT_EN
            row_hit_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            x0_q         <= x0_d;
            x1_q         <= x1_d;
            y1_q         <= y1_d;
            x_q          <= x_d;
            y_q          <= y_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            row_latch_q  <= row_latch_d;
            row_count_q  <= row_count_d;
            pix_latch_q  <= pix_latch_d;
            pix_count_q  <= pix_count_d;
            frag_valid_q <= frag_valid_d;
            frag_x_q     <= frag_x_d;
            frag_y_q     <= frag_y_d;
`ifdef SAPH_RASTER_EARLY_EXIT_EN
            row_hit_q    <= row_hit_d;
`endif
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign row_latch  = row_latch_q;
    assign row_count  = {EDGES{row_count_q}};
    assign pix_latch  = pix_latch_q;
    assign pix_count  = {EDGES{pix_count_q}};
    assign frag_valid = frag_valid_q;
    assign frag_x     = frag_x_q;
    assign frag_y     = frag_y_q;

endmodule

// File: tb/tb_saph_raster_walker.sv
// Self-checking bench for saph_raster_walker: behavioural incrementer model,
// per-cycle protocol invariants and a loop-based reference of the raster walk.
module tb_saph_raster_walker;

    localparam int unsigned EDGES = 3;
    localparam int unsigned XW    = 11;
    localparam int unsigned YW    = 11;
`ifdef SAPH_RASTER_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst, start, frag_ready;
    logic [XW-1:0]    bbox_x0, bbox_x1;
    logic [YW-1:0]    bbox_y0, bbox_y1;
    logic             busy, done, row_latch, pix_latch, frag_valid;
    logic [EDGES-1:0] row_count, pix_count, edge_neg;
    logic             row_ready, pix_ready;
    logic [XW-1:0]    frag_x;
    logic [YW-1:0]    frag_y;

    always #5 clk = ~clk;

    saph_raster_walker #(.EDGES(EDGES), .XW(XW), .YW(YW)) dut (
        .clk(clk), .rst(rst), .start(start),
        .bbox_x0(bbox_x0), .bbox_x1(bbox_x1), .bbox_y0(bbox_y0), .bbox_y1(bbox_y1),
        .busy(busy), .done(done),
        .row_latch(row_latch), .row_count(row_count), .row_ready(row_ready),
        .pix_latch(pix_latch), .pix_count(pix_count), .pix_ready(pix_ready),
        .edge_neg(edge_neg),
        .frag_valid(frag_valid), .frag_ready(frag_ready),
        .frag_x(frag_x), .frag_y(frag_y)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // Coverage map [y][x]; the incrementer pair is modelled by tracked coordinates.
    bit   cov [16][16];
    int   max_dly   = 0;
    int   fixed_dly = -1;
    int   ry = 0, px = 0, py = 0, rwait = 0, pwait = 0;
    logic [EDGES-1:0] garbage = '0;

    function automatic int pick();
        if (fixed_dly >= 0) return fixed_dly;
        return 1 + int'($urandom_range(32'(max_dly), 0));
    endfunction

    // Incrementer model: latch/count move the evaluated point, ready drops for a while.
    always @(posedge clk) begin
        garbage <= EDGES'($urandom);
        if (rst) begin
            rwait <= 0;
            pwait <= 0;
        end else begin
            if (row_latch) begin
                ry <= int'(bbox_y0); rwait <= pick();
            end else if (row_count != '0) begin
                ry <= ry + 1; rwait <= pick();
            end else if (rwait > 0) begin
                rwait <= rwait - 1;
            end
            if (pix_latch) begin
                px <= int'(bbox_x0); py <= ry; pwait <= pick();
            end else if (pix_count != '0) begin
                px <= px + 1; pwait <= pick();
            end else if (pwait > 0) begin
                pwait <= pwait - 1;
            end
        end
    end

    assign row_ready = (rwait == 0);
    assign pix_ready = (pwait == 0);

    // Sign bits are junk while the pixel incrementer is not ready.
    always_comb begin
        if (pwait != 0)
            edge_neg = garbage;
        else if (px >= 0 && px < 16 && py >= 0 && py < 16 && cov[py][px])
            edge_neg = '0;
        else
            edge_neg = EDGES'(1);
    end

    // Monitor: handshakes, pulse counts and pending-hold capture at the active edge.
    int   fx_q[$], fy_q[$];
    int   n_rowc = 0, n_pixc = 0, n_done = 0;
    bit   hold_pending = 1'b0;
    logic [XW-1:0] hold_x;
    logic [YW-1:0] hold_y;

    always @(posedge clk) begin
        if (rst) begin
            hold_pending = 1'b0;
        end else begin
            if (frag_valid && frag_ready) begin
                fx_q.push_back(int'(frag_x));
                fy_q.push_back(int'(frag_y));
            end
            if (row_count != '0) n_rowc++;
            if (pix_count != '0) n_pixc++;
            if (done) n_done++;
            hold_pending = frag_valid && !frag_ready;
            hold_x = frag_x;
            hold_y = frag_y;
        end
    end

    // Protocol invariants checked every cycle away from the active edge.
    logic prev_rl = 1'b0, prev_pl = 1'b0, prev_rc = 1'b0, prev_pc = 1'b0, prev_dn = 1'b0;
    always @(negedge clk) begin
        if (!rst) begin
            check("latch_count_overlap",
                  32'((row_latch || pix_latch) && (row_count != '0 || pix_count != '0)), 0);
            check("pulse_width", 32'((row_latch && prev_rl) || (pix_latch && prev_pl) ||
                  (row_count != '0 && prev_rc) || (pix_count != '0 && prev_pc) ||
                  (done && prev_dn)), 0);
            check("count_all_ones", 32'((row_count == '0 || row_count == '1) &&
                  (pix_count == '0 || pix_count == '1)), 1);
            if (hold_pending) begin
                check("frag_hold_valid", 32'(frag_valid), 1);
                check("frag_hold_x", 32'(frag_x), 32'(hold_x));
                check("frag_hold_y", 32'(frag_y), 32'(hold_y));
            end
        end
        prev_rl = row_latch;
        prev_pl = pix_latch;
        prev_rc = (row_count != '0);
        prev_pc = (pix_count != '0);
        prev_dn = done;
    end

    // Reference walk: raster loops over the box with the coverage map.
    int exp_x[$], exp_y[$];
    int exp_npc, exp_nrc;

    task automatic build_model(input int x0, input int x1, input int y0, input int y1);
        int visited;
        bit hit;
        exp_x.delete();
        exp_y.delete();
        exp_npc = 0;
        exp_nrc = y1 - y0;
        for (int y = y0; y <= y1; y++) begin
            hit = 1'b0;
            visited = 0;
            for (int x = x0; x <= x1; x++) begin
                visited++;
                if (cov[y][x]) begin
                    exp_x.push_back(x);
                    exp_y.push_back(y);
                    hit = 1'b1;
                end else if (EARLY && hit) begin
                    break;
                end
            end
            exp_npc += visited - 1;
        end
    endtask

    task automatic clear_cov();
        for (int y = 0; y < 16; y++)
            for (int x = 0; x < 16; x++)
                cov[y][x] = 1'b0;
    endtask

    task automatic check_outputs_zero(input string pfx);
        check({pfx, "_busy"}, 32'(busy), 0);
        check({pfx, "_done"}, 32'(done), 0);
        check({pfx, "_frag_valid"}, 32'(frag_valid), 0);
        check({pfx, "_row_latch"}, 32'(row_latch), 0);
        check({pfx, "_pix_latch"}, 32'(pix_latch), 0);
        check({pfx, "_row_count"}, 32'(row_count), 0);
        check({pfx, "_pix_count"}, 32'(pix_count), 0);
        check({pfx, "_frag_x"}, 32'(frag_x), 0);
        check({pfx, "_frag_y"}, 32'(frag_y), 0);
    endtask

    // One complete walk from a negedge; compares against the reference model.
    task automatic run_walk(input int x0, input int x1, input int y0, input int y1,
                            input int rdy_pct, input bit poke);
        bit seen_done;
        bbox_x0 = XW'(x0);
        bbox_x1 = XW'(x1);
        bbox_y0 = YW'(y0);
        bbox_y1 = YW'(y1);
        build_model(x0, x1, y0, y1);
        fx_q.delete();
        fy_q.delete();
        n_rowc = 0;
        n_pixc = 0;
        n_done = 0;
        frag_ready = 1'b0;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", 32'(busy), 1);
        seen_done = 1'b0;
        for (int cyc = 0; cyc < 3000 && !seen_done; cyc++) begin
            frag_ready = ($urandom_range(99, 0) < 32'(rdy_pct));
            start = poke && busy && ($urandom_range(4, 0) == 0);
            @(posedge clk);
            @(negedge clk);
            if (done) seen_done = 1'b1;
        end
        start = 1'b0;
        frag_ready = 1'b0;
        check("walk_done_seen", 32'(seen_done), 1);
        @(posedge clk);
        @(negedge clk);
        check("busy_clear_after_done", 32'(busy), 0);
        check("done_pulse_count", 32'(n_done), 1);
        check("frag_count", 32'(fx_q.size()), 32'(exp_x.size()));
        for (int i = 0; i < exp_x.size(); i++) begin
            if (i < fx_q.size()) begin
                check("frag_x_order", 32'(fx_q[i]), 32'(exp_x[i]));
                check("frag_y_order", 32'(fy_q[i]), 32'(exp_y[i]));
            end
        end
        check("pix_count_pulses", 32'(n_pixc), 32'(exp_npc));
        check("row_count_pulses", 32'(n_rowc), 32'(exp_nrc));
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        int x0, y0, w, h;
        rst = 1'b1;
        start = 1'b0;
        frag_ready = 1'b0;
        bbox_x0 = '0; bbox_x1 = '0; bbox_y0 = '0; bbox_y1 = '0;
        clear_cov();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_outputs_zero("reset");
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);

        // Single row, all covered.
        max_dly = 0;
        clear_cov();
        for (int x = 2; x <= 4; x++) cov[3][x] = 1'b1;
        run_walk(2, 4, 3, 3, 100, 1'b0);
        check("row_walk_pix_count", 32'(n_pixc), 2);
        check("row_walk_row_count", 32'(n_rowc), 0);

        // 2x2 box with (1,0) uncovered.
        clear_cov();
        cov[0][0] = 1'b1; cov[1][0] = 1'b1; cov[1][1] = 1'b1;
        run_walk(0, 1, 0, 1, 100, 1'b0);
        check("square_frags", 32'(fx_q.size()), 3);
        check("square_row_count", 32'(n_rowc), 1);

        // Single pixel with a five-cycle consumer stall.
        clear_cov();
        cov[0][0] = 1'b1;
        bbox_x0 = '0; bbox_x1 = '0; bbox_y0 = '0; bbox_y1 = '0;
        frag_ready = 1'b0;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 0; cyc < 200 && !frag_valid; cyc++) begin
            @(posedge clk);
            @(negedge clk);
        end
        for (int i = 0; i < 5; i++) begin
            check("stall_valid", 32'(frag_valid), 1);
            check("stall_x", 32'(frag_x), 0);
            check("stall_y", 32'(frag_y), 0);
            check("stall_no_done", 32'(done), 0);
            @(posedge clk);
            @(negedge clk);
        end
        frag_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        frag_ready = 1'b0;
        check("stall_done_after_hs", 32'(done), 1);
        check("stall_valid_dropped", 32'(frag_valid), 0);
        @(posedge clk);
        @(negedge clk);
        check("stall_done_one_cycle", 32'(done), 0);
        check("stall_busy_clear", 32'(busy), 0);

        // Reset in the middle of an 8-pixel row at the third fragment.
        max_dly = 1;
        clear_cov();
        for (int x = 0; x < 8; x++) cov[0][x] = 1'b1;
        bbox_x0 = '0; bbox_x1 = XW'(7); bbox_y0 = '0; bbox_y1 = '0;
        fx_q.delete();
        fy_q.delete();
        n_done = 0;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        frag_ready = 1'b1;
        found = 1'b0;
        for (int cyc = 0; cyc < 500 && !found; cyc++) begin
            if (frag_valid && frag_x == XW'(2)) begin
                found = 1'b1;
            end else begin
                @(posedge clk);
                @(negedge clk);
            end
        end
        check("midwalk_third_frag_seen", 32'(found), 1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_outputs_zero("midwalk_rst");
        rst = 1'b0;
        frag_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("midwalk_no_done", 32'(done), 0);
        check("midwalk_done_count", 32'(n_done), 0);
        check("midwalk_frags_before_rst", 32'(fx_q.size()), 2);
        clear_cov();
        cov[2][1] = 1'b1; cov[2][2] = 1'b1; cov[3][3] = 1'b1;
        run_walk(1, 3, 2, 3, 80, 1'b1);

        // Covered span x=2..3 on an 8-pixel row.
        max_dly = 0;
        clear_cov();
        cov[0][2] = 1'b1; cov[0][3] = 1'b1;
        run_walk(0, 7, 0, 0, 100, 1'b0);
        check("span_pix_count", 32'(n_pixc), EARLY ? 32'd4 : 32'd7);

        // Pixel incrementer slow to become ready.
        fixed_dly = 4;
        clear_cov();
        for (int y = 1; y <= 2; y++)
            for (int x = 1; x <= 4; x++)
                cov[y][x] = 1'($urandom_range(1, 0));
        run_walk(1, 4, 1, 2, 100, 1'b0);
        fixed_dly = -1;

        // Randomized boxes, coverage, ready latencies and back-pressure.
        for (int t = 0; t < 25; t++) begin
            x0 = int'($urandom_range(10, 0));
            y0 = int'($urandom_range(10, 0));
            w  = int'($urandom_range(4, 0));
            h  = int'($urandom_range(3, 0));
            max_dly = int'($urandom_range(3, 0));
            clear_cov();
            for (int y = y0; y <= y0 + h; y++)
                for (int x = x0; x <= x0 + w; x++)
                    cov[y][x] = ($urandom_range(99, 0) < 60);
            run_walk(x0, x0 + w, y0, y0 + h, int'($urandom_range(100, 30)), 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
